// File: rtl/radio_en_sequencer.sv
// Per-channel radio enable / receive-enable sequencer with guard interval,
// optional output pipeline and a zero-latency isolation clamp.
module radio_en_sequencer #(
  parameter int NCH     = 2,
  parameter int GUARD_W = 4,
  parameter int PIPE    = 0
) (
  input  logic               ck,
  input  logic               arst,
  input  logic               isolate,
  input  logic [GUARD_W-1:0] guard_cycles,
  input  logic [NCH-1:0]     enable_req,
  input  logic [NCH-1:0]     rx_en_req,
  output logic [NCH-1:0]     radio_en,
  output logic [NCH-1:0]     radio_rx_en,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     abort_pulse
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_EN_ONLY = 3'd1,
    ST_RAMP_UP = 3'd2,
    ST_RX_ON   = 3'd3,
    ST_RAMP_DN = 3'd4
  } state_t;

  localparam int               BW       = 4 * NCH;
  localparam logic [GUARD_W-1:0] CNT_ZERO = {GUARD_W{1'b0}};
  localparam logic [GUARD_W-1:0] CNT_ONE  = GUARD_W'(1'b1);

  state_t             state_r    [NCH];
  state_t             state_nx_s [NCH];
  logic [GUARD_W-1:0] cnt_r      [NCH];
  logic [GUARD_W-1:0] cnt_nx_s   [NCH];

  logic [NCH-1:0] any_req_s;
  logic [NCH-1:0] abort_nx_s;
  logic [NCH-1:0] en_nx_s;
  logic [NCH-1:0] rx_nx_s;
  logic [NCH-1:0] busy_nx_s;

  logic [NCH-1:0] en_r;
  logic [NCH-1:0] rx_r;
  logic [NCH-1:0] busy_r;
  logic [NCH-1:0] abort_r;

  logic [BW-1:0]  fsm_bus_s;
  logic [BW-1:0]  out_bus_s;
  logic [BW-1:0]  gated_bus_s;

  // A receive request implies the radio itself must be enabled.
  assign any_req_s = enable_req | rx_en_req;

  // State and guard-counter registers for every channel
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= ST_OFF;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
      end
    end
  end

  // Next-state, counter and abort decisions per channel
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      abort_nx_s[i] = 1'b0;
      if (isolate) begin
        state_nx_s[i] = ST_OFF;
        cnt_nx_s[i]   = CNT_ZERO;
      end else begin
        case (state_r[i])
          ST_OFF: begin
            if (rx_en_req[i]) begin
              state_nx_s[i] = ST_RAMP_UP;
              cnt_nx_s[i]   = guard_cycles;
            end else if (any_req_s[i]) begin
              state_nx_s[i] = ST_EN_ONLY;
            end else begin
              state_nx_s[i] = ST_OFF;
            end
          end
          ST_EN_ONLY: begin
            if (rx_en_req[i]) begin
              state_nx_s[i] = ST_RAMP_UP;
              cnt_nx_s[i]   = guard_cycles;
            end else if (!any_req_s[i]) begin
              state_nx_s[i] = ST_OFF;
            end else begin
              state_nx_s[i] = ST_EN_ONLY;
            end
          end
          ST_RAMP_UP: begin
            if (!rx_en_req[i]) begin
              abort_nx_s[i] = 1'b1;
              state_nx_s[i] = enable_req[i] ? ST_EN_ONLY : ST_OFF;
            end else if (cnt_r[i] == CNT_ZERO) begin
              state_nx_s[i] = ST_RX_ON;
            end else begin
              cnt_nx_s[i]   = cnt_r[i] - CNT_ONE;
            end
          end
          ST_RX_ON: begin
            if (!rx_en_req[i]) begin
              if (enable_req[i]) begin
                state_nx_s[i] = ST_EN_ONLY;
              end else begin
                state_nx_s[i] = ST_RAMP_DN;
                cnt_nx_s[i]   = guard_cycles;
              end
            end else begin
              state_nx_s[i] = ST_RX_ON;
            end
          end
          ST_RAMP_DN: begin
            // Re-request wins over everything, then plain enable, then the guard.
            if (rx_en_req[i]) begin
              state_nx_s[i] = ST_RAMP_UP;
              cnt_nx_s[i]   = guard_cycles;
            end else if (enable_req[i]) begin
              state_nx_s[i] = ST_EN_ONLY;
            end else if (cnt_r[i] == CNT_ZERO) begin
              state_nx_s[i] = ST_OFF;
            end else begin
              cnt_nx_s[i]   = cnt_r[i] - CNT_ONE;
            end
          end
          default: begin
            state_nx_s[i] = ST_OFF;
            cnt_nx_s[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Output decode from the next state so the FSM outputs land in registers
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      en_nx_s[i]   = 1'b0;
      rx_nx_s[i]   = 1'b0;
      busy_nx_s[i] = 1'b0;
      case (state_nx_s[i])
        ST_OFF: begin
          en_nx_s[i]   = 1'b0;
        end
        ST_EN_ONLY: begin
          en_nx_s[i]   = 1'b1;
        end
        ST_RAMP_UP: begin
          en_nx_s[i]   = 1'b1;
          busy_nx_s[i] = 1'b1;
        end
        ST_RX_ON: begin
          en_nx_s[i]   = 1'b1;
          rx_nx_s[i]   = 1'b1;
        end
        ST_RAMP_DN: begin
          en_nx_s[i]   = 1'b1;
          busy_nx_s[i] = 1'b1;
        end
        default: begin
          en_nx_s[i]   = 1'b0;
        end
      endcase
    end
  end

  // FSM output registers
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      en_r    <= {NCH{1'b0}};
      rx_r    <= {NCH{1'b0}};
      busy_r  <= {NCH{1'b0}};
      abort_r <= {NCH{1'b0}};
    end else begin
      en_r    <= en_nx_s;
      rx_r    <= rx_nx_s;
      busy_r  <= busy_nx_s;
      abort_r <= abort_nx_s;
    end
  end

  assign fsm_bus_s = {abort_r, busy_r, rx_r, en_r};

  generate
    if (PIPE == 0) begin : g_nopipe
      assign out_bus_s = fsm_bus_s;
    end else begin : g_pipe
      logic [BW-1:0] pipe_r [PIPE];

      // Equal-delay retiming of all four output groups; isolate flushes it
      always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
          for (int k = 0; k < PIPE; k++) begin
            pipe_r[k] <= {BW{1'b0}};
          end
        end else if (isolate) begin
          for (int k = 0; k < PIPE; k++) begin
            pipe_r[k] <= {BW{1'b0}};
          end
        end else begin
          pipe_r[0] <= fsm_bus_s;
          for (int k = 1; k < PIPE; k++) begin
            pipe_r[k] <= pipe_r[k-1];
          end
        end
      end

      assign out_bus_s = pipe_r[PIPE-1];
    end
  endgenerate

  // Isolation clamp is combinational so it takes effect in the same cycle.
  assign gated_bus_s = {BW{~isolate}} & out_bus_s;
  assign {abort_pulse, busy, radio_rx_en, radio_en} = gated_bus_s;

endmodule

// File: tb/tb_radio_en_sequencer.sv
// Randomized bench for radio_en_sequencer: PIPE=0 and PIPE=2 instances share
// stimulus and are compared against a behavioural per-channel model.
module tb_radio_en_sequencer;

  localparam int NCH = 2;
  localparam int GW  = 4;
  localparam int BW  = 4 * NCH;
  localparam int NCYC = 3000;

  logic          ck = 1'b0;
  logic          arst;
  logic          isolate;
  logic [GW-1:0] guard_cycles;
  logic [NCH-1:0] enable_req;
  logic [NCH-1:0] rx_en_req;

  logic [NCH-1:0] en0, rx0, busy0, ab0;
  logic [NCH-1:0] en2, rx2, busy2, ab2;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: ramp remaining counts (-1 = not ramping) and output bits
  int up_rem [NCH];
  int dn_rem [NCH];
  bit en_m   [NCH];
  bit rx_m   [NCH];
  bit ab_m   [NCH];
  logic [BW-1:0] p1_m, p2_m;

  always #5 ck = ~ck;

  radio_en_sequencer #(.NCH(NCH), .GUARD_W(GW), .PIPE(0)) dut0 (
    .ck(ck), .arst(arst), .isolate(isolate), .guard_cycles(guard_cycles),
    .enable_req(enable_req), .rx_en_req(rx_en_req),
    .radio_en(en0), .radio_rx_en(rx0), .busy(busy0), .abort_pulse(ab0)
  );

  radio_en_sequencer #(.NCH(NCH), .GUARD_W(GW), .PIPE(2)) dut2 (
    .ck(ck), .arst(arst), .isolate(isolate), .guard_cycles(guard_cycles),
    .enable_req(enable_req), .rx_en_req(rx_en_req),
    .radio_en(en2), .radio_rx_en(rx2), .busy(busy2), .abort_pulse(ab2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [BW-1:0] model_bus();
    logic [BW-1:0] v;
    v = {BW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      v[i]         = en_m[i];
      v[NCH+i]     = rx_m[i];
      v[2*NCH+i]   = (up_rem[i] >= 0) || (dn_rem[i] >= 0);
      v[3*NCH+i]   = ab_m[i];
    end
    return v;
  endfunction

  task automatic model_clear_channels();
    for (int i = 0; i < NCH; i++) begin
      up_rem[i] = -1;
      dn_rem[i] = -1;
      en_m[i]   = 1'b0;
      rx_m[i]   = 1'b0;
      ab_m[i]   = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_clear_channels();
    p1_m = {BW{1'b0}};
    p2_m = {BW{1'b0}};
  endtask

  // one clock edge of the reference, using the inputs held across the edge
  task automatic model_edge();
    logic [BW-1:0] o_old;
    bit r, e, eq;
    int g;
    o_old = model_bus();
    g = int'(guard_cycles);
    if (isolate) begin
      model_reset();
    end else begin
      p2_m = p1_m;
      p1_m = o_old;
      for (int i = 0; i < NCH; i++) begin
        r  = rx_en_req[i];
        eq = enable_req[i];
        e  = eq | r;
        ab_m[i] = 1'b0;
        if (up_rem[i] >= 0) begin
          if (!r) begin
            ab_m[i]   = 1'b1;
            up_rem[i] = -1;
            en_m[i]   = eq;
          end else if (up_rem[i] == 0) begin
            up_rem[i] = -1;
            rx_m[i]   = 1'b1;
          end else begin
            up_rem[i]--;
          end
        end else if (dn_rem[i] >= 0) begin
          if (r) begin
            dn_rem[i] = -1;
            up_rem[i] = g;
          end else if (eq) begin
            dn_rem[i] = -1;
          end else if (dn_rem[i] == 0) begin
            dn_rem[i] = -1;
            en_m[i]   = 1'b0;
          end else begin
            dn_rem[i]--;
          end
        end else if (rx_m[i]) begin
          if (!r) begin
            rx_m[i] = 1'b0;
            if (!eq) dn_rem[i] = g;
          end
        end else begin
          if (r) begin
            en_m[i]   = 1'b1;
            up_rem[i] = g;
          end else begin
            en_m[i]   = e;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string sfx);
    logic [BW-1:0] exp0, exp2;
    exp0 = isolate ? {BW{1'b0}} : model_bus();
    exp2 = isolate ? {BW{1'b0}} : p2_m;
    check_eq({"pipe0", sfx}, {24'd0, ab0, busy0, rx0, en0}, {24'd0, exp0});
    check_eq({"pipe2", sfx}, {24'd0, ab2, busy2, rx2, en2}, {24'd0, exp2});
  endtask

  initial begin
    arst         = 1'b1;
    isolate      = 1'b0;
    guard_cycles = 4'd0;
    enable_req   = {NCH{1'b0}};
    rx_en_req    = {NCH{1'b0}};
    model_reset();
    #3;
    check_outputs("_reset");
    @(negedge ck);
    arst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge ck);
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 7) == 0) rx_en_req[ch] = ~rx_en_req[ch];
        if ($urandom_range(0, 5) == 0) enable_req[ch] = ~enable_req[ch];
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) guard_cycles = GW'($urandom_range(0, 15));
        else guard_cycles = GW'($urandom_range(0, 5));
      end
      if (isolate) begin
        if ($urandom_range(0, 2) == 0) isolate = 1'b0;
      end else begin
        if ($urandom_range(0, 59) == 0) isolate = 1'b1;
      end
      if ($urandom_range(0, 249) == 0) begin
        arst = 1'b1;
        model_reset();
        #1;
        check_outputs("_arst");
        arst = 1'b0;
      end
      #1;
      check_outputs("");
      @(posedge ck);
      model_edge();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/radio_en_sequencer.md
Name: radio_en_sequencer

Overview:
- Parametrised successor to the per-link radio-enable retiming stage in the timing-engine path.
- Takes already-synchronised per-channel enable and receive-enable requests and produces registered `radio_en` / `radio_rx_en` per channel.
- Enforces a programmable guard interval: enable asserts before rx-enable on the way up, and stays asserted after rx-enable drops on the way down.
- Adds an isolation clamp that zeroes all outputs and resets sequencing. Sits between the timing engine and the radio control outputs.

Parameters:
- NCH, 2: number of independent radio channels.
- GUARD_W, 4: width of the guard-cycle count input.
- PIPE, 0: extra output register stages (0..4) appended after the FSM output registers.

Ports:
- ck  input  1  clock
- arst  input  1  asynchronous reset, active-high
- isolate  input  1  isolation request; clamps outputs, forces all channels OFF
- guard_cycles  input  GUARD_W  guard length; sampled on entry to RAMP_UP/RAMP_DN
- enable_req  input  NCH  per-channel radio enable request
- rx_en_req  input  NCH  per-channel receive enable request (implies enable)
- radio_en  output  NCH  per-channel radio enable
- radio_rx_en  output  NCH  per-channel receive enable
- busy  output  NCH  channel in RAMP_UP or RAMP_DN
- abort_pulse  output  NCH  1-cycle pulse when a RAMP_UP is abandoned

Behaviour:
- Clocking and reset: single clock ck. arst is asynchronous and active-high. While arst is high:
  - all FSMs are OFF and all counters are 0;
  - all pipeline stages are 0;
  - radio_en, radio_rx_en, busy and abort_pulse are all 0.
- Each channel has an independent FSM and a GUARD_W-bit down-counter `cnt`.
- Per-channel request terms: R = rx_en_req[i]; E = enable_req[i] | R.
- States and registered outputs (radio_en, radio_rx_en, busy):
  - OFF: 0,0,0
  - EN_ONLY: 1,0,0
  - RAMP_UP: 1,0,1
  - RX_ON: 1,1,0
  - RAMP_DN: 1,0,1
- Transitions (evaluated each edge, isolate=0):
  - OFF:
    - R -> RAMP_UP, cnt <= guard_cycles.
    - else E -> EN_ONLY.
  - EN_ONLY:
    - R -> RAMP_UP, cnt <= guard_cycles.
    - else !E -> OFF.
  - RAMP_UP:
    - !R -> abort_pulse=1 for one cycle; go to EN_ONLY if enable_req, else OFF.
    - else cnt==0 -> RX_ON.
    - else cnt <= cnt-1.
  - RX_ON:
    - !R and enable_req -> EN_ONLY (no guard needed; enable stays high).
    - !R and !enable_req -> RAMP_DN, cnt <= guard_cycles.
  - RAMP_DN (checked in this order):
    - R -> RAMP_UP, cnt <= guard_cycles.
    - enable_req -> EN_ONLY.
    - cnt==0 -> OFF.
    - else cnt <= cnt-1.
- Latency (PIPE=0):
  - radio_en rises 1 edge after a request is first sampled.
  - radio_rx_en rises guard_cycles+1 edges after radio_en.
  - On rx drop with enable_req=0, radio_rx_en falls 1 edge after sampling; radio_en falls guard_cycles+1 edges later.
- guard_cycles=0 is legal: RAMP_UP/RAMP_DN last exactly 1 cycle. guard_cycles changes mid-ramp have no effect until the next ramp entry.
- PIPE>0 delays radio_en, radio_rx_en, busy and abort_pulse by PIPE cycles, equally.
- Isolation:
  - isolate=1 gates radio_en, radio_rx_en, busy and abort_pulse to 0 combinationally at the final output, with zero latency.
  - On every edge with isolate=1, every FSM goes to OFF, cnt <= 0, all pipeline stages <= 0, and requests are ignored.
  - After isolate falls, channels restart from OFF. A held R re-enters RAMP_UP with a full guard.
- Channels are fully independent. No shared arbitration.
- Reset mid-ramp: immediate OFF. No abort_pulse is generated.

Test Plan:
- Reset then rx_en_req[0]=1, guard=3, PIPE=0 -> radio_en[0]=1 after edge 1, busy[0]=1 for 4 cycles, radio_rx_en[0]=1 after edge 5; channel 1 outputs stay 0.
- From RX_ON drop rx_en_req[0], enable_req[0]=0, guard=2 -> radio_rx_en falls after edge 1, radio_en falls after edge 4; with enable_req[0]=1 instead -> radio_en stays 1, state EN_ONLY, busy never asserts.
- guard=5, rx_en_req pulse 3 cycles -> abort_pulse one cycle, radio_rx_en never rises, radio_en returns 0 one edge after the drop.
- RX_ON on both channels, isolate=1 mid-cycle -> all outputs 0 same cycle. Release isolate with rx_en_req held, guard=1 -> radio_en after 1 edge, radio_rx_en 2 edges later.
- guard=0, PIPE=2 -> radio_en at edge 3, radio_rx_en at edge 4; repeat with arst pulsed during RAMP_UP -> all outputs 0 immediately, no abort_pulse.
- RAMP_DN (guard=4), rx_en_req re-asserted after 2 cycles -> RAMP_UP reloads guard 4. radio_en never drops; radio_rx_en returns 5 edges later.
